// File: rtl/pulse_arbiter.sv
// Round-robin arbiter that turns latched single-cycle events from NREQ sources
// into stretched pulses of programmable width and gap, tagged with the source index.
module pulse_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CBW  = 2,
  parameter int GBW  = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic [CBW-1:0]  CYCLE,
  input  logic [GBW-1:0]  GAP,
  input  logic            CLR_OVF,
  output logic            DOUT,
  output logic [IDW-1:0]  DOUT_ID,
  output logic            BUSY,
  output logic [NREQ-1:0] PEND,
  output logic [NREQ-1:0] OVF
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  last;
  logic [CBW-1:0]  cnt;
  logic [GBW-1:0]  gcnt;
  logic [IDW-1:0]  pick;
  logic            found;
  logic [NREQ-1:0] grant;

  // Scan starting just after the last winner so every source gets a turn.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!found && PEND[(int'(last) + off) % NREQ]) begin
        found = 1'b1;
        pick  = IDW'((int'(last) + off) % NREQ);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == ST_IDLE && found) begin
      grant[pick] = 1'b1;
    end
  end

  // A request arriving on its own grant edge re-arms PEND without counting as lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PEND <= '0;
      OVF  <= '0;
    end else begin
      PEND <= (PEND & ~grant) | REQ;
      OVF  <= (REQ & PEND & ~grant) | (CLR_OVF ? '0 : OVF);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      DOUT    <= 1'b0;
      DOUT_ID <= '0;
      BUSY    <= 1'b0;
      last    <= IDW'(NREQ - 1);
      cnt     <= '0;
      gcnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state   <= ST_PULSE;
            DOUT    <= 1'b1;
            DOUT_ID <= pick;
            BUSY    <= 1'b1;
            last    <= pick;
            cnt     <= CYCLE;
            gcnt    <= GAP;
          end
        end
        ST_PULSE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            DOUT <= 1'b0;
            if (gcnt != '0) begin
              state <= ST_GAP;
            end else begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          gcnt <= gcnt - 1'b1;
          if (gcnt == GBW'(1)) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          DOUT  <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_arbiter.sv
// Directed bench for pulse_arbiter: reset, burst, single event, round-robin,
// overflow and asynchronous reset in mid-pulse, all with hand-computed expectations.
module tb_pulse_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic [1:0] CYCLE;
  logic [1:0] GAP;
  logic       CLR_OVF;
  logic       DOUT;
  logic [1:0] DOUT_ID;
  logic       BUSY;
  logic [3:0] PEND;
  logic [3:0] OVF;

  int checks   = 0;
  int failures = 0;

  pulse_arbiter #(.NREQ(4), .IDW(2), .CBW(2), .GBW(2)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .CYCLE(CYCLE), .GAP(GAP), .CLR_OVF(CLR_OVF),
    .DOUT(DOUT), .DOUT_ID(DOUT_ID), .BUSY(BUSY), .PEND(PEND), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output at once.
  task automatic chk_all(input string tag, input logic dout, input logic [1:0] id,
                         input logic busy, input logic [3:0] pend, input logic [3:0] ovf);
    chk({tag, ".dout"}, 32'(DOUT), 32'(dout));
    chk({tag, ".id"},   32'(DOUT_ID), 32'(id));
    chk({tag, ".busy"}, 32'(BUSY), 32'(busy));
    chk({tag, ".pend"}, 32'(PEND), 32'(pend));
    chk({tag, ".ovf"},  32'(OVF), 32'(ovf));
    $display("step %-10s t=%0t dout=%b id=%0d busy=%b pend=%b ovf=%b",
             tag, $time, DOUT, DOUT_ID, BUSY, PEND, OVF);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; REQ = 4'b1111; CYCLE = 2'd0; GAP = 2'd0; CLR_OVF = 1'b0;

    // Reset held for 3 cycles with all requests active
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("rst", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
    end
    RST = 1'b0;

    // Burst: all four requests for one edge, CYCLE=0 GAP=0
    tick(); chk_all("b_k",  1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000);
    REQ = 4'b0000;
    tick(); chk_all("b_g0", 1'b1, 2'd0, 1'b1, 4'b1110, 4'b0000);
    tick(); chk_all("b_l0", 1'b0, 2'd0, 1'b0, 4'b1110, 4'b0000);
    tick(); chk_all("b_g1", 1'b1, 2'd1, 1'b1, 4'b1100, 4'b0000);
    tick(); chk_all("b_l1", 1'b0, 2'd1, 1'b0, 4'b1100, 4'b0000);
    tick(); chk_all("b_g2", 1'b1, 2'd2, 1'b1, 4'b1000, 4'b0000);
    tick(); chk_all("b_l2", 1'b0, 2'd2, 1'b0, 4'b1000, 4'b0000);
    tick(); chk_all("b_g3", 1'b1, 2'd3, 1'b1, 4'b0000, 4'b0000);
    tick(); chk_all("b_l3", 1'b0, 2'd3, 1'b0, 4'b0000, 4'b0000);

    // Single event on requester 2 with CYCLE=3, GAP=1
    CYCLE = 2'd3; GAP = 2'd1; REQ = 4'b0100;
    tick(); chk_all("s_k", 1'b0, 2'd3, 1'b0, 4'b0100, 4'b0000);
    REQ = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      tick(); chk_all("s_hi", 1'b1, 2'd2, 1'b1, 4'b0000, 4'b0000);
    end
    tick(); chk_all("s_gap",  1'b0, 2'd2, 1'b1, 4'b0000, 4'b0000);
    tick(); chk_all("s_idle", 1'b0, 2'd2, 1'b0, 4'b0000, 4'b0000);

    // Round-robin: serve 1, then {0,3} pending together -> 3 before 0
    CYCLE = 2'd0; GAP = 2'd0; REQ = 4'b0010;
    tick(); chk_all("r_a",  1'b0, 2'd2, 1'b0, 4'b0010, 4'b0000);
    REQ = 4'b1001;
    tick(); chk_all("r_g1", 1'b1, 2'd1, 1'b1, 4'b1001, 4'b0000);
    REQ = 4'b0000;
    tick(); chk_all("r_l1", 1'b0, 2'd1, 1'b0, 4'b1001, 4'b0000);
    tick(); chk_all("r_g3", 1'b1, 2'd3, 1'b1, 4'b0001, 4'b0000);
    REQ = 4'b0010;
    tick(); chk_all("r_l3", 1'b0, 2'd3, 1'b0, 4'b0011, 4'b0000);
    REQ = 4'b0000;
    tick(); chk_all("r_g0", 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0000);
    tick(); chk_all("r_l0", 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000);
    tick(); chk_all("r_g1b", 1'b1, 2'd1, 1'b1, 4'b0000, 4'b0000);
    tick(); chk_all("r_l1b", 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000);

    // Overflow on requester 1 while 0's 4-cycle pulse runs
    CYCLE = 2'd3; REQ = 4'b0001;
    tick(); chk_all("o_b",  1'b0, 2'd1, 1'b0, 4'b0001, 4'b0000);
    REQ = 4'b0010;
    tick(); chk_all("o_g0", 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0000);
    tick(); chk_all("o_ovf", 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0010);
    REQ = 4'b0000; CLR_OVF = 1'b1;
    tick(); chk_all("o_clr", 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0000);
    REQ = 4'b0010;
    tick(); chk_all("o_setwin", 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0010);
    REQ = 4'b0000; CLR_OVF = 1'b0;
    tick(); chk_all("o_end0", 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_all("o_hi1", 1'b1, 2'd1, 1'b1, 4'b0000, 4'b0010);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("o_once", 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0010);
    end

    // Asynchronous reset during the 2nd high cycle of a pulse
    REQ = 4'b0011;
    tick(); chk_all("m_k",   1'b0, 2'd1, 1'b0, 4'b0011, 4'b0010);
    REQ = 4'b0000;
    tick(); chk_all("m_hi1", 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0010);
    tick(); chk_all("m_hi2", 1'b1, 2'd0, 1'b1, 4'b0010, 4'b0010);
    #2 RST = 1'b1;
    #1 chk_all("m_async", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
    tick();
    RST = 1'b0; REQ = 4'b1000;
    tick(); chk_all("m_req3", 1'b0, 2'd0, 1'b0, 4'b1000, 4'b0000);
    REQ = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_all("m_hi3", 1'b1, 2'd3, 1'b1, 4'b0000, 4'b0000);
    end
    tick(); chk_all("m_end", 1'b0, 2'd3, 1'b0, 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_arbiter.md
# pulse_arbiter

Shares one stretched-pulse output between NREQ single-cycle event sources (e.g. per-lane bit-error strobes in the BER checker). Each event is latched as pending and served round-robin. Each served event becomes a pulse of programmable length followed by a programmable low gap. DOUT_ID tags the pulse with the requester index, so a slow observer (LED, sampling logic analyser, status register) can separate events from different sources.

## Interface
- NREQ, 4, number of requesters (2..1<<IDW)
- IDW, 2, width of requester index
- CBW, 2, width of CYCLE (pulse length control)
- GBW, 2, width of GAP (inter-pulse gap control)

- CLK  input  1  clock
- RST  input  1  reset, asynchronous, active-high
- REQ  input  NREQ  per-requester event strobe, one event per high cycle
- CYCLE  input  CBW  pulse length minus one, sampled at grant
- GAP  input  GBW  extra low cycles after each pulse, sampled at grant
- CLR_OVF  input  1  clears all OVF bits
- DOUT  output  1  stretched pulse
- DOUT_ID  output  IDW  index of requester being served; holds last value when idle
- BUSY  output  1  high while not in IDLE
- PEND  output  NREQ  registered pending flags
- OVF  output  NREQ  sticky: event lost because requester already pending

## Operation
- States: IDLE, PULSE, GAP. All outputs registered. Reset values: state IDLE, DOUT 0, DOUT_ID 0, BUSY 0, PEND 0, OVF 0, round-robin pointer LAST = NREQ-1, so requester 0 has first priority.
- Pending update per edge: PEND <= (PEND & ~GRANT) | REQ. GRANT is one-hot and is non-zero only on the IDLE→PULSE edge.
- Overflow: OVF[i] <= 1 when REQ[i] & PEND[i] & ~GRANT[i]. Otherwise OVF[i] <= 0 when CLR_OVF, else hold. If set and clear coincide, set wins.
- REQ[i] on the same edge that grants i re-arms PEND[i]. This is not an overflow.
- IDLE: if PEND != 0, pick the first set bit scanning LAST+1, LAST+2, … modulo NREQ. On that edge:
  - go to PULSE
  - DOUT <= 1, DOUT_ID <= index, LAST <= index
  - cnt <= CYCLE, gcnt <= GAP (both latched)
  - If PEND == 0, stay in IDLE.
- PULSE: DOUT high. If cnt != 0, cnt <= cnt-1. If cnt == 0: DOUT <= 0, then go to GAP if gcnt != 0, else IDLE.
- GAP: DOUT low. gcnt <= gcnt-1. When gcnt == 1, go to IDLE.
- Arbitration happens only in IDLE. The IDLE state is always occupied for at least one cycle between pulses.
- CYCLE and GAP changes during a pulse do not affect that pulse.
- RST asserted in any state returns every register to its reset value immediately. A pulse in progress is truncated; pending events and OVF are discarded.

## Timing
- Latency: REQ[i] sampled at edge k sets PEND[i] after edge k. If idle and i wins, DOUT rises after edge k+1. DOUT_ID is valid from that same edge.
- Pulse width: exactly CYCLE+1 cycles high (1 .. 1<<CBW).
- Low time between consecutive pulses while work is pending: exactly GAP+1 cycles (GAP cycles in GAP state + 1 IDLE cycle).
- Throughput per event: CYCLE+GAP+2 cycles.
- BUSY is high for CYCLE+1+GAP cycles per event.
- Worst-case wait for a pending requester: (NREQ-1) full event periods plus the event in progress.
- PEND[i] clears on the grant edge, so it is already low during i's pulse.

## Test plan
- Reset: hold RST 3 cycles with REQ=4'b1111 → DOUT, BUSY, PEND, OVF, DOUT_ID all 0 during and after reset; first grant after release goes to requester 0.
- Single event: CYCLE=3, GAP=1, REQ[2] pulsed at edge k → PEND[2]=1 after k; DOUT=1 and DOUT_ID=2 after edges k+1..k+4; BUSY high 5 cycles; DOUT low and state IDLE after k+6.
- Burst: CYCLE=0, GAP=0, REQ=4'b1111 for one cycle → DOUT pattern 1,0,1,0,1,0,1 with DOUT_ID 0,1,2,3; OVF stays 0.
- Round-robin: after serving 1, set PEND to {0,3} in the same cycle → 3 served before 0. A new REQ[1] during 3's pulse is served after 0.
- Overflow: REQ[1] at two edges while 1 is pending and not granted → OVF[1]=1, PEND[1]=1, one pulse for 1. CLR_OVF alone clears OVF[1]. CLR_OVF coincident with a new overflow leaves OVF[1]=1.
- Reset mid-pulse: CYCLE=3, assert RST during the 2nd high cycle → DOUT, BUSY and PEND drop without waiting for CLK. After release and REQ[3], the pulse is a full 4 cycles with DOUT_ID=3.
